// File: rtl/pce_scan_sequencer_if.sv
// pce_scan_sequencer_if: console SEL/CLR pins, six-button mode select and the
// bank/mux control outputs of the scan sequencer.
interface pce_scan_sequencer_if #(
    parameter int SCAN_CNT_W = 8
);
    logic                  sel;
    logic                  clr;
    logic                  six_en;
    logic                  bank;
    logic                  nibble;
    logic                  drive_zero;
    logic                  latch;
    logic                  timed_out;
    logic [SCAN_CNT_W-1:0] scan_count;

    modport master (
        output sel, clr, six_en,
        input  bank, nibble, drive_zero, latch, timed_out, scan_count
    );

    modport slave (
        input  sel, clr, six_en,
        output bank, nibble, drive_zero, latch, timed_out, scan_count
    );
endinterface

// File: rtl/pce_scan_sequencer.sv
// pce_scan_sequencer: synchronises console SEL/CLR, detects scan starts on CLR
// falling edges and selects the six-button bank, with an idle timeout back to bank 0.
module pce_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int CNT_W          = 16,
    parameter int SCAN_CNT_W     = 8
) (
    input  logic                 system_clock,
    input  logic                 reset,
    pce_scan_sequencer_if.slave  bus
);
    localparam logic [0:0]       IDLE   = 1'b0;
    localparam logic [0:0]       ACTIVE = 1'b1;
    localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic                  sel_m_q, sel_s_q;
    logic                  clr_m_q, clr_s_q, clr_d_q;
    logic [1:0]            flush_q, flush_d;
    logic                  armed_q, armed_d;
    logic [0:0]            state_q, state_d;
    logic                  nibble_q;
    logic                  bank_q, bank_d;
    logic                  next_bank_q, next_bank_d;
    logic                  latch_q, latch_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SCAN_CNT_W-1:0] scan_count_q, scan_count_d;
    logic                  scan_start;

    // The synchroniser resets high, so a CLR held low through reset would look like
    // a falling edge; arm edge detection only after a genuine high has been sampled.
    always_comb begin
        flush_d      = {flush_q[0], 1'b1};
        armed_d      = armed_q | (flush_q[1] & clr_s_q);
        scan_start   = (state_q == IDLE) & armed_q & clr_d_q & ~clr_s_q;
        state_d      = scan_start ? ACTIVE :
                       (state_q == ACTIVE && clr_s_q) ? IDLE : state_q;
        latch_d      = scan_start;
        bank_d       = scan_start ? next_bank_q : bank_q;
        cnt_d        = scan_start ? '0 : (cnt_q == T_MAX) ? cnt_q : cnt_q + 1'b1;
        next_bank_d  = !bus.six_en      ? 1'b0 :
                       scan_start       ? ~next_bank_q :
                       (cnt_d == T_MAX) ? 1'b0 : next_bank_q;
        scan_count_d = scan_count_q + SCAN_CNT_W'(scan_start);
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            sel_m_q      <= 1'b1;
            sel_s_q      <= 1'b1;
            clr_m_q      <= 1'b1;
            clr_s_q      <= 1'b1;
            clr_d_q      <= 1'b1;
            flush_q      <= '0;
            armed_q      <= 1'b0;
            state_q      <= IDLE;
            nibble_q     <= 1'b1;
            bank_q       <= 1'b0;
            next_bank_q  <= 1'b0;
            latch_q      <= 1'b0;
            cnt_q        <= '0;
            scan_count_q <= '0;
        end else begin
            sel_m_q      <= bus.sel;
            sel_s_q      <= sel_m_q;
            clr_m_q      <= bus.clr;
            clr_s_q      <= clr_m_q;
            clr_d_q      <= clr_s_q;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
            state_q      <= state_d;
            nibble_q     <= sel_s_q;
            bank_q       <= bank_d;
            next_bank_q  <= next_bank_d;
            latch_q      <= latch_d;
            cnt_q        <= cnt_d;
            scan_count_q <= scan_count_d;
        end
    end

    assign bus.bank       = bank_q;
    assign bus.nibble     = nibble_q;
    assign bus.drive_zero = (state_q == IDLE);
    assign bus.latch      = latch_q;
    assign bus.timed_out  = (cnt_q == T_MAX);
    assign bus.scan_count = scan_count_q;
endmodule

// File: doc/pce_scan_sequencer.md
Name: pce_scan_sequencer

Overview:
- Sits between the console-side SEL/CLR pins and the six-button output mux, in the `system_clock` domain.
- Synchronises SEL and CLR and detects each console scan, which starts on a CLR falling edge.
- Decides which bank the mux must present: bank 0 is I/II/Select/Run plus the D-pad; bank 1 is III–VI plus the all-low ID nibble.
- Issues a one-cycle latch strobe so the button snapshot stays stable for the whole scan, and returns to bank 0 after an idle timeout.

Parameters:
- TIMEOUT_CYCLES, 20000: idle cycles with no scan start before the bank phase resets to 0. At 20 MHz this is 1 ms.
- CNT_W, 16: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.
- SCAN_CNT_W, 8: width of the wrapping scan counter.

Ports:
- system_clock, input, 1: single clock, 20 MHz nominal.
- reset, input, 1: synchronous, active-high.
- sel, input, 1: console SEL, asynchronous. 1 = direction nibble, 0 = button nibble.
- clr, input, 1: console CLR, asynchronous. 1 = outputs forced low or idle, 0 = scan active.
- six_en, input, 1: 1 = six-button bank alternation, 0 = always bank 0.
- bank, output, 1: bank the mux must present for the current scan.
- nibble, output, 1: synchronised SEL. 1 = directions, 0 = buttons.
- drive_zero, output, 1: 1 while CLR is high. The mux then outputs 4'b0000.
- latch, output, 1: one-cycle pulse at scan start. Downstream captures the button inputs on this pulse.
- timed_out, output, 1: high while the idle counter is saturated.
- scan_count, output, SCAN_CNT_W: number of scan starts since reset, wrapping.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. Reset takes priority over every other event, including mid-scan.
- Reset values:
  - SEL and CLR synchroniser flops = 1.
  - Edge-detect flop = 1.
  - state = IDLE.
  - bank = 0; next_bank = 0.
  - nibble = 1; drive_zero = 1; latch = 0.
  - timeout counter = 0; timed_out = 0; scan_count = 0.
- Synchronisation: 2-flop synchroniser per input, giving sel_s and clr_s. One extra flop on clr_s gives clr_d for edge detection.
- Scan start: scan_start = clr_d & ~clr_s.
- Latency: a pin change becomes visible on the outputs 3 clock edges after the first synchroniser samples it.
- nibble: registered copy of sel_s, updated every cycle regardless of state.
- FSM state IDLE (drive_zero = 1):
  - On scan_start, go to ACTIVE and perform the scan-start actions below.
- Scan-start actions, all in one cycle:
  - latch = 1 for exactly that cycle.
  - bank <= next_bank.
  - next_bank <= six_en ? ~next_bank : 0.
  - scan_count increments.
  - Timeout counter clears to 0.
- FSM state ACTIVE (drive_zero = 0):
  - When clr_s = 1, go to IDLE; drive_zero = 1 from the next cycle.
  - bank stays constant for the whole scan, including while SEL toggles.
- Timeout counter:
  - Increments every cycle in both states, saturating at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: timed_out = 1 and next_bank <= 0. bank itself is unchanged until the next scan start.
  - timed_out clears on the next scan start.
- Simultaneous events:
  - scan_start in the same cycle the counter would reach TIMEOUT_CYCLES: scan_start wins. bank <= the current next_bank, the counter clears, and timed_out stays 0.
  - six_en falling: next_bank <= 0 immediately; the current bank is held until the end of the scan.
- Glitches and short pulses:
  - A CLR low pulse shorter than one clock may be missed. This is acceptable.
  - A CLR low pulse of 2 or more cycles must produce exactly one latch.
- scan_count wraps from 2^SCAN_CNT_W−1 to 0.

Test Plan:
- Reset, then six_en = 1, then 4 scans, each CLR low for 13 µs, 30 µs apart → bank = 0,1,0,1; exactly 4 latch pulses, each 1 cycle wide; scan_count = 4.
- six_en = 0, 3 scans → bank = 0 on every scan; next_bank stays 0.
- six_en = 1, 1 scan (bank 0), then 1.1 ms idle → timed_out = 1 at exactly 20000 cycles after the latch; the next scan gives bank = 0 and timed_out = 0.
- Hold CLR high, toggle SEL; then CLR low, toggle SEL → drive_zero = 1 throughout the first phase; nibble follows SEL with 3-cycle latency; bank is unchanged during the scan.
- Assert reset mid-scan (CLR low, bank = 1) → the cycle after reset, all outputs are at their reset values; with CLR still low there is no latch until CLR goes high and then falls again.
- Timing: CLR falls so that scan_start lands on the cycle the counter reaches TIMEOUT_CYCLES → bank = pre-timeout next_bank, timed_out stays 0, counter = 0.
